// File: rtl/key_debounce_conditioner_if.sv
// Button-conditioner signal bundle: raw pins and software clears in,
// debounced level, edge pulses and sticky press flags out.
interface key_debounce_conditioner_if #(
   parameter int WIDTH = 2
);
   logic [WIDTH-1:0] raw_in;
   logic [WIDTH-1:0] clear_events;
   logic [WIDTH-1:0] level_out;
   logic [WIDTH-1:0] press_pulse;
   logic [WIDTH-1:0] release_pulse;
   logic [WIDTH-1:0] event_flags;

   // Board/software side: drives pins and clears, observes conditioned outputs
   modport master (
      output raw_in,
      output clear_events,
      input  level_out,
      input  press_pulse,
      input  release_pulse,
      input  event_flags
   );

   // Conditioner side
   modport slave (
      input  raw_in,
      input  clear_events,
      output level_out,
      output press_pulse,
      output release_pulse,
      output event_flags
   );
endinterface

// File: rtl/key_debounce_conditioner.sv
// Per-bit push-button conditioner: 2-flop synchronizer, polarity
// normalisation, counter debounce, registered press/release pulses and
// sticky press flags. Bits are fully independent.
module key_debounce_conditioner #(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   key_debounce_conditioner_if.slave    bus
);

   // Count value at which a persistent difference is accepted
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   // Synchronizer reset value is the "not pressed" pin level so reset exit is silent
   localparam logic [WIDTH-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] sync2_q, sync2_d;
   logic [WIDTH-1:0] level_q, level_d;
   logic [WIDTH-1:0] press_q, press_d;
   logic [WIDTH-1:0] release_q, release_d;
   logic [WIDTH-1:0] flags_q, flags_d;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0] norm;

   // Next-state: synchronize, normalise, debounce, derive pulses and flags
   always_comb begin
      sync1_d   = bus.raw_in;
      sync2_d   = sync1_q;
      norm      = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (norm[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               // Difference has persisted long enough: accept the new level
               level_d[i]   = norm[i];
               press_d[i]   = norm[i];
               release_d[i] = ~norm[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
      // A press arriving together with a clear must not be lost
      flags_d = press_q | (flags_q & ~bus.clear_events);
   end

   // State registers; reset discards any partial debounce count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q   <= IDLE_RAW;
         sync2_q   <= IDLE_RAW;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         flags_q   <= '0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         flags_q   <= flags_d;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign bus.level_out     = level_q;
   assign bus.press_pulse   = press_q;
   assign bus.release_pulse = release_q;
   assign bus.event_flags   = flags_q;

endmodule

// File: tb/tb_key_debounce_conditioner.sv
// Directed bench for key_debounce_conditioner (DEBOUNCE_CYCLES=4, active-low pins).
// Expected pulse events are queued by the stimulus; a negedge monitor pops
// them whenever the DUT shows a pulse and checks value and arrival cycle.
module tb_key_debounce_conditioner;

   localparam int W  = 2;
   localparam int DC = 4;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   typedef struct {
      logic [W-1:0] pp;
      logic [W-1:0] rp;
      logic [W-1:0] lvl;
      int           cyc;
   } exp_t;
   exp_t exp_q[$];

   key_debounce_conditioner_if #(.WIDTH(W)) bus ();

   key_debounce_conditioner #(
      .WIDTH(W), .DEBOUNCE_CYCLES(DC), .CNT_W(3), .ACTIVE_LOW(1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Queue a pulse event expected DC+2 edges after the current drive point
   task automatic expect_evt(input logic [W-1:0] pp, input logic [W-1:0] rp, input logic [W-1:0] lvl);
      exp_t e;
      e.pp = pp; e.rp = rp; e.lvl = lvl; e.cyc = cyc + DC + 2;
      exp_q.push_back(e);
   endtask

   // Monitor: every pulse must match the head of the scoreboard, on time
   always @(negedge clk) begin
      if (!reset) begin
         if ((bus.press_pulse | bus.release_pulse) != '0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", {26'd0, bus.press_pulse, bus.release_pulse, bus.level_out}, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("pulse_evt",
                   {bus.press_pulse, bus.release_pulse, bus.level_out, 26'(cyc)},
                   {e.pp, e.rp, e.lvl, 26'(e.cyc)});
            end
         end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pulse_timeout", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      reset            = 1'b1;
      bus.raw_in       = 2'b11;
      bus.clear_events = 2'b00;

      // 1: reset held 3 cycles with idle pins, then 20 quiet cycles
      tick(1);
      chk("rst_level", 32'(bus.level_out), 32'd0);
      chk("rst_pulses", 32'({bus.press_pulse, bus.release_pulse}), 32'd0);
      chk("rst_flags", 32'(bus.event_flags), 32'd0);
      tick(2);
      reset = 1'b0;
      tick(20);
      chk("post_rst_level", 32'(bus.level_out), 32'd0);
      chk("post_rst_flags", 32'(bus.event_flags), 32'd0);

      // 2: press bit 0, check exact acceptance edge
      bus.raw_in[0] = 1'b0;
      expect_evt(2'b01, 2'b00, 2'b01);
      tick(DC + 1);
      chk("press0_not_early", 32'(bus.level_out), 32'd0);
      tick(1);
      chk("press0_level", 32'(bus.level_out), 32'd1);
      chk("press0_pulse", 32'(bus.press_pulse), 32'd1);
      tick(1);
      chk("press0_pulse_1cyc", 32'(bus.press_pulse), 32'd0);
      chk("press0_flag", 32'(bus.event_flags), 32'd1);

      // 3: 3-cycle glitch on bit 1 is rejected
      bus.raw_in[1] = 1'b0;
      tick(3);
      bus.raw_in[1] = 1'b1;
      tick(10);
      chk("glitch1_level", 32'(bus.level_out), 32'd1);
      chk("glitch1_flags", 32'(bus.event_flags), 32'd1);

      // 4: clear flag 0, then release bit 0
      bus.clear_events[0] = 1'b1;
      tick(1);
      bus.clear_events[0] = 1'b0;
      chk("clear0_flag", 32'(bus.event_flags), 32'd0);
      bus.raw_in[0] = 1'b1;
      expect_evt(2'b00, 2'b01, 2'b00);
      tick(DC + 2);
      chk("release0_pulse", 32'(bus.release_pulse), 32'd1);
      tick(1);
      chk("release0_level", 32'(bus.level_out), 32'd0);
      chk("release0_flag", 32'(bus.event_flags), 32'd0);

      // 5: clear in the same cycle as press pulse -> set wins
      bus.raw_in[0] = 1'b0;
      expect_evt(2'b01, 2'b00, 2'b01);
      tick(DC + 2);
      chk("press0b_pulse", 32'(bus.press_pulse), 32'd1);
      bus.clear_events[0] = 1'b1;
      tick(1);
      bus.clear_events[0] = 1'b0;
      chk("setwins_flag", 32'(bus.event_flags), 32'd1);
      bus.clear_events[0] = 1'b1;
      tick(1);
      bus.clear_events[0] = 1'b0;
      chk("clear0b_flag", 32'(bus.event_flags), 32'd0);

      // Release again to return bit 0 to idle
      bus.raw_in[0] = 1'b1;
      expect_evt(2'b00, 2'b01, 2'b00);
      tick(DC + 3);
      chk("release0b_level", 32'(bus.level_out), 32'd0);

      // 6: reset mid-debounce (cnt=2), raw held low across reset
      bus.raw_in[0] = 1'b0;
      tick(4);
      reset = 1'b1;
      tick(2);
      chk("midrst_level", 32'(bus.level_out), 32'd0);
      reset = 1'b0;
      expect_evt(2'b01, 2'b00, 2'b01);
      tick(DC + 1);
      chk("midrst_not_early", 32'(bus.level_out), 32'd0);
      tick(1);
      chk("midrst_level_up", 32'(bus.level_out), 32'd1);

      tick(3);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
